l_frag_cfg_loader: RTL and testbench
====================================

// Module: l_frag_cfg_loader
// PURPOSE
//  Serial configuration loader sitting directly upstream of a chain of NUM_FRAGS L_FRAG LUT fragments.
//  - Accepts a bit-serial config stream (valid/ready) into a shadow register.
//  - Verifies a 16-bit XOR checksum, then commits all fragBitInfo words at once.
//  - On a bad checksum the live LUT contents are left unchanged.
// PARAMETERS
//  NUM_FRAGS  4   number of driven L_FRAGs; each takes one 16-bit fragBitInfo word
//  INIT_CFG   0   reset value of the fragBitInfo bus, width 16*NUM_FRAGS
//  CHECK_EN   1   1: 16-bit checksum phase follows the data; 0: no checksum phase, commit unconditionally
// PORTS
//  QCK          in   1             clock, all logic on its rising edge
//  QRT          in   1             reset, synchronous, active-high
//  CfgStart     in   1             one-cycle pulse, begins (or restarts) a load
//  CfgBit       in   1             serial config data bit
//  CfgValid     in   1             CfgBit is valid this cycle
//  CfgReady     out  1             loader accepts a bit this cycle
//  fragBitInfo  out  16*NUM_FRAGS  live LUT config; word k = bits [16k+15:16k] feeds fragment k
//  CfgBusy      out  1             load in progress (LOAD or CHECK)
//  CfgDone      out  1             one-cycle pulse, commit performed
//  CfgError     out  1             sticky, checksum mismatch on the last load
// BEHAVIOUR
//  Reset (QRT=1 at an edge):
//   - state=IDLE, bit counter=0, shadow=0, running XOR=0
//   - fragBitInfo=INIT_CFG; CfgReady, CfgBusy, CfgDone, CfgError all 0
//   - QRT has priority over every other input, including mid-load; a partial load is discarded
//  Transfer rule: a bit transfers only on an edge with CfgValid&CfgReady; CfgValid gaps stall the load with no penalty.
//  CfgReady is a registered function of state: 1 in LOAD/CHECK, 0 otherwise.
//  States:
//   - IDLE: CfgStart -> LOAD, counter=0, shadow=0, XOR=0, CfgError cleared. CfgValid is ignored.
//   - LOAD:
//     - Each transferred bit goes to shadow[counter]; the counter increments.
//     - Order: word 0 first, LSB first within each word (matches fragBitInfo[0]..[15] LUT addressing).
//     - The running XOR is updated per completed 16-bit word.
//     - After bit 16*NUM_FRAGS-1 transfers: -> CHECK if CHECK_EN=1, else -> COMMIT.
//   - CHECK: 16 checksum bits shift in LSB first; after the 16th -> COMMIT.
//   - COMMIT (one cycle, CfgReady=0):
//     - If CHECK_EN=0, or checksum == XOR of all data words: fragBitInfo<=shadow and CfgDone=1 on this cycle.
//     - Otherwise CfgError=1 and fragBitInfo is held.
//     - Always -> IDLE.
//  Latency: CfgDone/fragBitInfo update one cycle after the edge accepting the final bit.
//  CfgBusy=1 in LOAD and CHECK only.
//  CfgStart in LOAD/CHECK aborts and restarts: counter, shadow and XOR cleared; a bit transferred on that same edge is dropped.
//  CfgStart in COMMIT is ignored.
//  CfgStart with CfgValid in IDLE: the bit is not accepted (CfgReady=0).
//  Counter width clog2(16*NUM_FRAGS+17); it saturates at the terminal count and never wraps.
//  Extra CfgValid after the final bit is ignored (CfgReady=0 in COMMIT/IDLE).
//  fragBitInfo changes only at reset or a successful COMMIT; it is glitch-free to the LUTs, registered.
// TESTING (NUM_FRAGS=2, CHECK_EN=1 unless stated)
//  1. Good load, back-to-back valid:
//     - Stimulus: start, words 16'hAAAA, 16'h8000, then checksum 16'h2AAA.
//     - Response: 48 beats, then CfgDone for 1 cycle; fragBitInfo=32'h8000_AAAA; CfgError=0.
//  2. Bad checksum:
//     - Stimulus: same words, checksum 16'h2AAB.
//     - Response: CfgError=1 (sticky), no CfgDone, fragBitInfo stays INIT_CFG; the next CfgStart clears CfgError.
//  3. Valid gaps:
//     - Stimulus: CfgValid toggled 1,0,1,0 through the load of test 1.
//     - Response: identical result; exactly 48 transfers counted.
//  4. Restart mid-load:
//     - Stimulus: CfgStart after 20 bits, then a full good load of 16'h1234, 16'h00FF, checksum 16'h12CB.
//     - Response: fragBitInfo=32'h00FF_1234.
//  5. Reset mid-load:
//     - Stimulus: QRT=1 after 30 bits.
//     - Response: next cycle CfgBusy=0, CfgReady=0, fragBitInfo=INIT_CFG; any valid bits after reset are ignored until CfgStart.
//  6. CHECK_EN=0:
//     - Stimulus: start, words 16'hFFFF, 16'h0001.
//     - Response: CfgDone one cycle after bit 32; fragBitInfo=32'h0001_FFFF.

Source files
------------

// File: rtl/l_frag_cfg_loader.sv
// l_frag_cfg_loader: bit-serial configuration loader for a chain of L_FRAG LUTs.
// Bits fill a shadow register, an XOR checksum is verified, then all words commit at once.
module l_frag_cfg_loader #(
    parameter int unsigned               NUM_FRAGS = 4,
    parameter logic [16*NUM_FRAGS-1:0]   INIT_CFG  = '0,
    parameter bit                        CHECK_EN  = 1'b1
) (
    input  logic                     QCK,
    input  logic                     QRT,
    input  logic                     CfgStart,
    input  logic                     CfgBit,
    input  logic                     CfgValid,
    output logic                     CfgReady,
    output logic [16*NUM_FRAGS-1:0]  fragBitInfo,
    output logic                     CfgBusy,
    output logic                     CfgDone,
    output logic                     CfgError
);
    localparam int unsigned DW = 16 * NUM_FRAGS;
    localparam int unsigned CW = $clog2(DW + 17);
    localparam int unsigned IW = $clog2(DW);

    localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CHK_LAST  = CW'(DW + 15);
    localparam logic [CW-1:0] TERM      = CW'(DW + 16);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_COMMIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   cfg_q, cfg_d;
    logic [15:0]     xor_q, xor_d;
    logic [15:0]     chk_q, chk_d;
    logic            rdy_q, rdy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            xfer;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   wbase;
    logic [CW-1:0]   cnt_inc;

    assign xfer    = CfgValid & rdy_q;
    assign idx     = cnt_q[IW-1:0];
    assign wbase   = idx & ~IW'(15);
    assign cnt_inc = (cnt_q == TERM) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        xor_d    = xor_q;
        chk_d    = chk_q;
        done_d   = 1'b0;
        err_d    = err_q;

        // A start outside COMMIT always (re)opens a clean load; any bit on this edge is dropped.
        if (CfgStart && state_q != S_COMMIT) begin
            state_d  = S_LOAD;
            cnt_d    = '0;
            shadow_d = '0;
            xor_d    = '0;
            chk_d    = '0;
            err_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_LOAD: begin
                    if (xfer) begin
                        cnt_d         = cnt_inc;
                        shadow_d[idx] = CfgBit;
                        if (idx[3:0] == 4'hF) begin
                            xor_d = xor_q ^ shadow_d[wbase +: 16];
                        end
                        if (cnt_q == DATA_LAST) begin
                            state_d = CHECK_EN ? S_CHECK : S_COMMIT;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        cnt_d = cnt_inc;
                        chk_d = {CfgBit, chk_q[15:1]};
                        if (cnt_q == CHK_LAST) begin
                            state_d = S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    if (!CHECK_EN || chk_q == xor_q) begin
                        cfg_d  = shadow_q;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        rdy_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    end

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            cfg_q    <= INIT_CFG;
            xor_q    <= '0;
            chk_q    <= '0;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            xor_q    <= xor_d;
            chk_q    <= chk_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign CfgReady    = rdy_q;
    assign CfgBusy     = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign CfgDone     = done_q;
    assign CfgError    = err_q;
    assign fragBitInfo = cfg_q;

endmodule

// File: tb/tb_l_frag_cfg_loader.sv
// tb_l_frag_cfg_loader: directed loads on a checked and an unchecked loader.
// Expected commit/error events are queued by the driver and matched by a monitor.
module tb_l_frag_cfg_loader;
    localparam logic [31:0] INIT1 = 32'hDEAD_BEEF;
    localparam logic [31:0] INIT0 = 32'h5555_0000;

    typedef struct {
        bit          which;
        bit          err;
        logic [31:0] frag;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cbit = 1'b0;
    logic valid = 1'b0;
    logic sel = 1'b0;

    logic        rdy1, busy1, done1, err1;
    logic        rdy0, busy0, done0, err0;
    logic [31:0] frag1, frag0;
    logic        rdy_s;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   beats = 0;
    int   last_acc = 0;
    logic err1_p = 1'b0;
    logic err0_p = 1'b0;
    ev_t  expq[$];

    always #5 clk = ~clk;

    assign rdy_s = sel ? rdy0 : rdy1;

    l_frag_cfg_loader #(
        .NUM_FRAGS(2),
        .INIT_CFG (INIT1),
        .CHECK_EN (1'b1)
    ) dut1 (
        .QCK        (clk),
        .QRT        (rst),
        .CfgStart   (start & ~sel),
        .CfgBit     (cbit),
        .CfgValid   (valid & ~sel),
        .CfgReady   (rdy1),
        .fragBitInfo(frag1),
        .CfgBusy    (busy1),
        .CfgDone    (done1),
        .CfgError   (err1)
    );

    l_frag_cfg_loader #(
        .NUM_FRAGS(2),
        .INIT_CFG (INIT0),
        .CHECK_EN (1'b0)
    ) dut0 (
        .QCK        (clk),
        .QRT        (rst),
        .CfgStart   (start & sel),
        .CfgBit     (cbit),
        .CfgValid   (valid & sel),
        .CfgReady   (rdy0),
        .fragBitInfo(frag0),
        .CfgBusy    (busy0),
        .CfgDone    (done0),
        .CfgError   (err0)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && valid && !start && rdy_s) begin
            beats <= beats + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic see(input bit w, input bit e, input logic [31:0] f);
        ev_t x;
        if (expq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: dut%0d err=%0d frag=%h at cycle %0d",
                     w, e, f, cyc);
        end else begin
            x = expq.pop_front();
            chk("ev_dut", 32'(w), 32'(x.which));
            chk("ev_err", 32'(e), 32'(x.err));
            chk("ev_frag", f, x.frag);
            chk("ev_latency", cyc, x.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done1 || (err1 && !err1_p)) see(1'b1, err1 && !done1, frag1);
            if (done0 || (err0 && !err0_p)) see(1'b0, err0 && !done0, frag0);
        end
        err1_p <= err1;
        err0_p <= err0;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic beat(input logic b, input bit gap);
        int t;
        t = 0;
        if (gap) begin
            valid = 1'b0;
            @(posedge clk);
            #1;
        end
        valid = 1'b1;
        cbit  = b;
        while (!rdy_s && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!rdy_s) begin
            checks++;
            $display("FAIL beat_timeout: ready=%0d after %0d cycles", rdy_s, t);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input bit gaps);
        for (int i = 0; i < 16; i++) beat(w[i], gaps);
    endtask

    task automatic load(input bit do_start, input logic [15:0] w0, input logic [15:0] w1,
                        input bit use_ck, input logic [15:0] ck, input bit gaps,
                        input bit exp_err, input logic [31:0] exp_frag);
        int  b0;
        ev_t x;
        if (do_start) pulse_start();
        b0 = beats;
        send(w0, gaps);
        send(w1, gaps);
        if (use_ck) send(ck, gaps);
        x.which = !sel;
        x.err   = exp_err;
        x.frag  = exp_frag;
        x.cyc   = last_acc + 1;
        expq.push_back(x);
        chk("beat_count", beats - b0, use_ck ? 32'd48 : 32'd32);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 8) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (expq.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d events pending, want 0", expq.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_error", 32'(err1), 32'd0);
        chk("rst_frag1", frag1, INIT1);
        chk("rst_frag0", frag0, INIT0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // bad checksum
        load(1'b1, 16'hAAAA, 16'h8000, 1'b1, 16'h2AAB, 1'b0, 1'b1, INIT1);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", 32'(err1), 32'd1);
        chk("bad_frag_held", frag1, INIT1);

        // good load, back to back
        pulse_start();
        chk("err_cleared", 32'(err1), 32'd0);
        chk("busy_in_load", 32'(busy1), 32'd1);
        load(1'b0, 16'hAAAA, 16'h8000, 1'b1, 16'h2AAA, 1'b0, 1'b0, 32'h8000_AAAA);
        drain();
        chk("good_error", 32'(err1), 32'd0);
        chk("good_busy", 32'(busy1), 32'd0);

        // valid gaps
        load(1'b1, 16'hAAAA, 16'h8000, 1'b1, 16'h2AAA, 1'b1, 1'b0, 32'h8000_AAAA);
        drain();

        // restart after 20 bits, bit on the restart edge dropped
        pulse_start();
        for (int i = 0; i < 20; i++) beat(1'b1, 1'b0);
        start = 1'b1;
        valid = 1'b1;
        cbit  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid = 1'b0;
        load(1'b0, 16'h1234, 16'h00FF, 1'b1, 16'h12CB, 1'b0, 1'b0, 32'h00FF_1234);
        drain();

        // reset after 30 bits
        pulse_start();
        for (int i = 0; i < 30; i++) beat(1'(i % 3 == 0), 1'b0);
        valid = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(busy1), 32'd0);
        chk("midrst_ready", 32'(rdy1), 32'd0);
        chk("midrst_frag", frag1, INIT1);
        b0 = beats;
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_beats", beats - b0, 32'd0);
        chk("postrst_ready", 32'(rdy1), 32'd0);
        chk("postrst_frag", frag1, INIT1);
        valid = 1'b0;

        // no checksum phase
        sel = 1'b1;
        load(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0001_FFFF);
        drain();
        chk("nochk_frag1_untouched", frag1, INIT1);

        repeat (4) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
